bcd_score_display: RTL
======================

Name: bcd_score_display

Overview:
- Parametrised successor to the fixed 4-digit score/seven-segment path in the game top level.
- Holds an N-digit BCD score register and accepts increment, decrement, clear and load commands.
- Drives one shared seven-segment bus, time-multiplexed across N digit enables.
- Exposes the raw BCD digits in parallel for the VGA renderer, plus overflow and underflow pulses for game logic.

Parameters:
- N_DIGITS, 4: number of BCD digits (1..8).
- SCAN_DIV, 50000: clk cycles each digit is enabled per scan step (>=2).
- ACTIVE_LOW, 1: 1 means seg and an are active-low; 0 means active-high.
- BLANK_LZ, 1: 1 blanks leading zeros; digit 0 is never blanked.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- inc  in  1  add 1 to score this cycle.
- dec  in  1  subtract 1 from score this cycle.
- clr  in  1  set score to 0.
- load  in  1  load score from load_val.
- load_val  in  4*N_DIGITS  BCD load value; digit i is at [4i+3:4i].
- digits  out  4*N_DIGITS  current BCD score, registered.
- ovf  out  1  one-cycle pulse on wrap from max to 0.
- unf  out  1  one-cycle pulse on wrap from 0 to max.
- seg  out  7  segment bus {g,f,e,d,c,b,a}, registered.
- an  out  N_DIGITS  one-hot digit enable, registered.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset, sampled on a clk edge with rst=1:
  - digits=0, ovf=0, unf=0.
  - scan counter=0, scan index=0.
  - seg and an driven to the all-off level (all 1s if ACTIVE_LOW, else all 0s).
- Reset wins over every command in the same cycle. Reset mid-scan restarts the scan at index 0.
- Command priority, evaluated per cycle: clr > load > (inc and dec both high: no change) > inc > dec.
- Score latency: digits updates on the edge that samples the command, so it is visible 1 cycle after the command.
- Increment:
  - Ripple-carry BCD: a digit at 9 becomes 0 and carries to the next digit.
  - At max (all 9s, i.e. 10^N-1), inc wraps to 0 and ovf=1 for exactly that cycle.
- Decrement:
  - Ripple-borrow BCD: a digit at 0 becomes 9 and borrows from the next digit.
  - At 0, dec wraps to all 9s and unf=1 for exactly that cycle.
- Load:
  - Each load_val digit greater than 9 is clamped to 9.
  - No ovf or unf pulse on load.
- Clear: no ovf or unf pulse.
- ovf and unf are 0 in every cycle without a wrap; they are never both 1.
- Scan:
  - Counter runs 0..SCAN_DIV-1. On the cycle it equals SCAN_DIV-1, it returns to 0 and the index advances.
  - Index runs 0..N_DIGITS-1, then wraps to 0.
  - The counter runs continuously and is unaffected by score commands.
- Output register:
  - Each cycle, an and seg are registered from the current index and digits.
  - They lag the index by 1 cycle and lag a digits change by 1 cycle, so 2 cycles from command to seg.
- an: bit[index] is the active level; all other bits are inactive.
- Blanking:
  - With BLANK_LZ=1, digit i (i>0) is blanked when digits i..N_DIGITS-1 are all 0.
  - A blanked digit drives seg all-off, but its an bit is still driven active.
- seg encoding, active-high, {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - With ACTIVE_LOW=1, seg is the bitwise inverse of these codes.
- Width: all arithmetic is per-digit 4-bit BCD; there is no binary intermediate wider than 4*N_DIGITS.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then idle with ACTIVE_LOW=1 -> digits=0, seg=7'h7F, an=4'hF during reset; 1 cycle after release, an=4'b1110 and seg=7'b1000000 (shows "0").
- Increment carry: load 0x0099, then inc -> digits=0x0100 the next cycle, ovf=0; with index=2, seg=1111001 ("1").
- Wrap both ways: load 0x9999, inc -> digits=0x0000 and ovf high for exactly 1 cycle; then dec -> 0x9999 and unf high for exactly 1 cycle.
- Priority: clr+load+inc in one cycle -> 0; load(0x1234)+inc -> 0x1234; inc+dec -> unchanged; load_val=0x00F5 -> 0x0095.
- Scan and blanking: SCAN_DIV=4, score 0x0007, BLANK_LZ=1 -> an steps 1110, 1101, 1011, 0111 every 4 cycles; seg=7 code (1111000) at index 0 and 7'h7F at indices 1-3; with BLANK_LZ=0, indices 1-3 show "0".
- Reset mid-operation: assert rst at index 2 with score 0x0042 -> the next cycle shows score 0 and seg/an all-off; the scan restarts at index 0 and a post-reset inc gives 0x0001.

Source files
------------

// File: rtl/bcd_score_display.sv
// N-digit BCD score register with inc/dec/clear/load commands, driving a
// time-multiplexed seven-segment bus plus parallel BCD digits for the renderer.
module bcd_score_display #(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_val,
  output logic [4*N_DIGITS-1:0]   digits,
  output logic                    ovf,
  output logic                    unf,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an
);

  localparam int unsigned DW = 4 * N_DIGITS;
  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0]          SEG_OFF = {7{ACTIVE_LOW != 0}};
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ACTIVE_LOW != 0}};

  logic [DW-1:0]       inc_v, dec_v, ld_v, digits_n;
  logic                carry, borrow, ovf_n, unf_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [IW-1:0]       idx_q, idx_n;
  logic [3:0]          cur;
  logic                any_nz, cur_blank;
  logic [6:0]          seg_hi, seg_d;
  logic [N_DIGITS-1:0] an_hi, an_d;

  // Ripple-carry/borrow BCD, clamped load, and command priority
  always_comb begin
    inc_v  = digits;
    dec_v  = digits;
    ld_v   = '0;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (carry) begin
        if (digits[4*i +: 4] == 4'd9) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = digits[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (digits[4*i +: 4] == 4'd0) begin
          dec_v[4*i +: 4] = 4'd9;
        end else begin
          dec_v[4*i +: 4] = digits[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      ld_v[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end

    digits_n = digits;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    if (clr) begin
      digits_n = '0;
    end else if (load) begin
      digits_n = ld_v;
    end else if (inc && dec) begin
      digits_n = digits;
    end else if (inc) begin
      digits_n = inc_v;
      ovf_n    = carry;
    end else if (dec) begin
      digits_n = dec_v;
      unf_n    = borrow;
    end
  end

  // Free-running scan counter and digit index
  always_comb begin
    cnt_n = cnt_q + CW'(1);
    idx_n = idx_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_n = '0;
      idx_n = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Select the scanned digit; it is blank when it and every higher digit are zero
  always_comb begin
    cur    = 4'd0;
    any_nz = 1'b0;
    an_hi  = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        cur      = digits[4*i +: 4];
        an_hi[i] = 1'b1;
      end
      if ((IW'(i) >= idx_q) && (digits[4*i +: 4] != 4'd0)) begin
        any_nz = 1'b1;
      end
    end
    cur_blank = (BLANK_LZ != 0) && (idx_q != '0) && !any_nz;

    case (cur)
      4'd0:    seg_hi = 7'b0111111;
      4'd1:    seg_hi = 7'b0000110;
      4'd2:    seg_hi = 7'b1011011;
      4'd3:    seg_hi = 7'b1001111;
      4'd4:    seg_hi = 7'b1100110;
      4'd5:    seg_hi = 7'b1101101;
      4'd6:    seg_hi = 7'b1111101;
      4'd7:    seg_hi = 7'b0000111;
      4'd8:    seg_hi = 7'b1111111;
      4'd9:    seg_hi = 7'b1101111;
      default: seg_hi = 7'b0000000;
    endcase
    if (cur_blank) begin
      seg_hi = 7'b0000000;
    end

    seg_d = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    an_d  = (ACTIVE_LOW != 0) ? ~an_hi : an_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
      seg    <= SEG_OFF;
      an     <= AN_OFF;
    end else begin
      digits <= digits_n;
      ovf    <= ovf_n;
      unf    <= unf_n;
      cnt_q  <= cnt_n;
      idx_q  <= idx_n;
      seg    <= seg_d;
      an     <= an_d;
    end
  end

endmodule
